// File: rtl/clock_logic_gate_leaf_if.sv
// Enable handshake and debug bundle between the clock controller side and one gate leaf.
// The controller (master) drives the async request and DFT/debug controls; the leaf answers.
interface clock_logic_gate_leaf_if #(
    parameter int CNT_W = 8
);
    logic             async_enable;
    logic             async_enable_ack;
    logic             gate_enable;
    logic             clock_running;
    logic             test_force_on;
    logic             count_clear;
    logic [CNT_W-1:0] toggle_count;

    modport master (
        output async_enable, test_force_on, count_clear,
        input  async_enable_ack, gate_enable, clock_running, toggle_count
    );

    modport slave (
        input  async_enable, test_force_on, count_clear,
        output async_enable_ack, gate_enable, clock_running, toggle_count
    );
endinterface

// File: rtl/clock_logic_gate_leaf.sv
// Clock gate leaf: synchronises the controller enable, sequences the ICG enable through
// on/off settle windows and returns a level ack once the gated clock is stable.
module clock_logic_gate_leaf #(
    parameter int SYNC_STAGES = 2,
    parameter int ON_SETTLE   = 4,
    parameter int OFF_SETTLE  = 2,
    parameter int CNT_W       = 8
) (
    input  logic                    i_clock,
    input  logic                    i_async_resetn,
    clock_logic_gate_leaf_if.slave  io_bus
);
    localparam int MAX_SETTLE = (ON_SETTLE > OFF_SETTLE) ? ON_SETTLE : OFF_SETTLE;
    localparam int CW         = (MAX_SETTLE == 0) ? 1 : $clog2(MAX_SETTLE + 1);

    typedef enum logic [1:0] {S_OFF, S_START, S_ON, S_STOP} state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_en_sync;
    state_t                 r_state, w_nxt;
    logic [CW-1:0]          r_settle, w_settle_nxt;
    logic                   w_inc;
    logic                   r_gate, r_ack, r_running;
    logic [CNT_W-1:0]       r_count;

    always_ff @(posedge i_clock or negedge i_async_resetn) begin
        if (!i_async_resetn) r_sync <= '0;
        else                 r_sync <= {r_sync[SYNC_STAGES-2:0], io_bus.async_enable};
    end
    assign w_en_sync = r_sync[SYNC_STAGES-1];

    // STOP ignores the request so the off-settle always runs to completion.
    always_comb begin
        w_nxt        = r_state;
        w_settle_nxt = r_settle;
        w_inc        = 1'b0;
        case (r_state)
            S_OFF: if (w_en_sync) begin
                w_nxt        = S_START;
                w_settle_nxt = CW'(ON_SETTLE);
                w_inc        = 1'b1;
            end
            S_START: begin
                if (!w_en_sync) begin
                    w_nxt        = S_STOP;
                    w_settle_nxt = CW'(OFF_SETTLE);
                end else if (r_settle == '0) begin
                    w_nxt = S_ON;
                end else begin
                    w_settle_nxt = r_settle - CW'(1);
                end
            end
            S_ON: if (!w_en_sync) begin
                w_nxt        = S_STOP;
                w_settle_nxt = CW'(OFF_SETTLE);
            end
            S_STOP: begin
                if (r_settle == '0) w_nxt = S_OFF;
                else                w_settle_nxt = r_settle - CW'(1);
            end
            default: w_nxt = S_OFF;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_async_resetn) begin
        if (!i_async_resetn) begin
            r_state   <= S_OFF;
            r_settle  <= '0;
            r_gate    <= 1'b0;
            r_ack     <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_settle  <= w_settle_nxt;
            r_gate    <= (w_nxt == S_START) || (w_nxt == S_ON) || io_bus.test_force_on;
            r_running <= (w_nxt == S_ON);
            // Ack entering STOP from ON is held through the whole off-settle; an aborted
            // START keeps it low.
            case (w_nxt)
                S_ON:    r_ack <= 1'b1;
                S_STOP:  r_ack <= (r_state == S_ON) || r_ack;
                default: r_ack <= 1'b0;
            endcase
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge i_clock or negedge i_async_resetn) begin
        if (!i_async_resetn)                r_count <= '0;
        else if (io_bus.count_clear)        r_count <= '0;
        else if (w_inc && (r_count != '1))  r_count <= r_count + CNT_W'(1);
    end

    assign io_bus.gate_enable      = r_gate;
    assign io_bus.async_enable_ack = r_ack;
    assign io_bus.clock_running    = r_running;
    assign io_bus.toggle_count     = r_count;
endmodule

// File: tb/tb_clock_logic_gate_leaf.sv
// Directed bench for the clock gate leaf; a second instance with a 2-bit counter shares the
// stimulus to exercise saturation.
module tb_clock_logic_gate_leaf;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0, frc = 1'b0, clr = 1'b0;
    int   total = 0, bad = 0;

    typedef struct { string tag; logic [15:0] exp; } exp_t;
    exp_t sb[$];

    clock_logic_gate_leaf_if #(.CNT_W(8)) if8 ();
    clock_logic_gate_leaf_if #(.CNT_W(2)) if2 ();

    assign if8.async_enable  = en;
    assign if8.test_force_on = frc;
    assign if8.count_clear   = clr;
    assign if2.async_enable  = en;
    assign if2.test_force_on = frc;
    assign if2.count_clear   = clr;

    clock_logic_gate_leaf #(.SYNC_STAGES(2), .ON_SETTLE(4), .OFF_SETTLE(2), .CNT_W(8)) u_dut (
        .i_clock(clk), .i_async_resetn(rst_n), .io_bus(if8.slave));
    clock_logic_gate_leaf #(.SYNC_STAGES(2), .ON_SETTLE(4), .OFF_SETTLE(2), .CNT_W(2)) u_sat (
        .i_clock(clk), .i_async_resetn(rst_n), .io_bus(if2.slave));

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [15:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [15:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Check gate/ack/running of the main instance against pushed expectations.
    task automatic chk3(input string t, input logic g, input logic a, input logic r);
        push({t, "_gate"}, 16'(g));
        push({t, "_ack"}, 16'(a));
        push({t, "_run"}, 16'(r));
        chk(16'(if8.gate_enable));
        chk(16'(if8.async_enable_ack));
        chk(16'(if8.clock_running));
    endtask

    initial begin
        // reset state
        tick(2);
        chk3("reset", 1'b0, 1'b0, 1'b0);
        push("reset_cnt", 16'd0); chk(16'(if8.toggle_count));
        rst_n = 1'b1;
        tick(1);

        // turn on: gate at edge 3, ack/running at edge 8
        en = 1'b1;
        tick(2); chk3("on_e2", 1'b0, 1'b0, 1'b0);
        tick(1); chk3("on_e3", 1'b1, 1'b0, 1'b0);
        tick(4); chk3("on_e7", 1'b1, 1'b0, 1'b0);
        tick(1); chk3("on_e8", 1'b1, 1'b1, 1'b1);
        push("on_cnt8", 16'd1); chk(16'(if8.toggle_count));
        push("on_cnt2", 16'd1); chk(16'(if2.toggle_count));
        clr = 1'b1; tick(1); clr = 1'b0;
        push("clr_cnt", 16'd0); chk(16'(if8.toggle_count));

        // turn off: gate/running drop at edge 3, ack at edge 6
        en = 1'b0;
        tick(2); chk3("off_e2", 1'b1, 1'b1, 1'b1);
        tick(1); chk3("off_e3", 1'b0, 1'b1, 1'b0);
        tick(2); chk3("off_e5", 1'b0, 1'b1, 1'b0);
        tick(1); chk3("off_e6", 1'b0, 1'b0, 1'b0);

        // abort during START at settle count 2
        en = 1'b1;
        tick(3); chk3("ab_e3", 1'b1, 1'b0, 1'b0);
        en = 1'b0;
        tick(3); chk3("ab_e6", 1'b0, 1'b0, 1'b0);
        tick(1); chk3("ab_e7", 1'b0, 1'b0, 1'b0);
        tick(1); chk3("ab_e8", 1'b0, 1'b0, 1'b0);
        tick(1); chk3("ab_e9", 1'b0, 1'b0, 1'b0);
        push("ab_cnt", 16'd1); chk(16'(if8.toggle_count));

        // re-enable during STOP
        en = 1'b1;
        tick(8); chk3("re_up", 1'b1, 1'b1, 1'b1);
        push("re_cnt_a", 16'd2); chk(16'(if8.toggle_count));
        en = 1'b0;
        tick(3); chk3("re_e3", 1'b0, 1'b1, 1'b0);
        en = 1'b1;
        tick(3); chk3("re_e6", 1'b0, 1'b0, 1'b0);
        tick(1); chk3("re_e7", 1'b1, 1'b0, 1'b0);
        push("re_cnt8", 16'd3); chk(16'(if8.toggle_count));
        push("re_cnt2", 16'd3); chk(16'(if2.toggle_count));
        tick(5); chk3("re_e12", 1'b1, 1'b1, 1'b1);

        // saturation of the 2-bit counter
        for (int i = 0; i < 2; i++) begin
            en = 1'b0; tick(8);
            en = 1'b1; tick(8);
        end
        push("sat_cnt8", 16'd5); chk(16'(if8.toggle_count));
        push("sat_cnt2", 16'd3); chk(16'(if2.toggle_count));
        push("sat_ack", 16'd1);  chk(16'(if8.async_enable_ack));

        // clear coincident with OFF->START
        en = 1'b0; tick(8);
        en = 1'b1; tick(2);
        clr = 1'b1; tick(1); clr = 1'b0;
        push("clrinc_cnt8", 16'd0); chk(16'(if8.toggle_count));
        push("clrinc_cnt2", 16'd0); chk(16'(if2.toggle_count));
        push("clrinc_gate", 16'd1); chk(16'(if8.gate_enable));
        tick(5); chk3("clrinc_on", 1'b1, 1'b1, 1'b1);

        // DFT force in OFF
        en = 1'b0; tick(8);
        chk3("pre_frc", 1'b0, 1'b0, 1'b0);
        frc = 1'b1;
        tick(1); chk3("frc_e1", 1'b1, 1'b0, 1'b0);
        tick(3); chk3("frc_e4", 1'b1, 1'b0, 1'b0);
        frc = 1'b0;
        tick(1); chk3("frc_rel", 1'b0, 1'b0, 1'b0);

        // async reset while ON, checked between clock edges
        en = 1'b1; tick(8);
        chk3("rst_pre", 1'b1, 1'b1, 1'b1);
        push("rst_pre_cnt", 16'd1); chk(16'(if8.toggle_count));
        #2 rst_n = 1'b0;
        #1;
        chk3("rst_async", 1'b0, 1'b0, 1'b0);
        push("rst_cnt8", 16'd0); chk(16'(if8.toggle_count));
        push("rst_cnt2", 16'd0); chk(16'(if2.toggle_count));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
